vtpg_stream_adapter: RTL and testbench
======================================

Name: vtpg_stream_adapter

Overview:
- Consumes the raw pixel-timing output of the video test-pattern generator (vs, vld, rgb) and converts it to a valid/ready pixel stream.
- Each pixel carries start-of-frame (sof) and end-of-line (eol) markers.
- An elastic FIFO absorbs downstream back-pressure; overflow is flagged, never stalled, because the source cannot be throttled.
- Reports measured line length and frame height for debug and status registers.

Parameters:
- PW, 8, bits per colour component; pixel is 3*PW bits.
- H_BITS, 12, width of the pixels-per-line measurement.
- V_BITS, 12, width of the lines-per-frame measurement.
- DEPTH, 16, FIFO entries; must be a power of 2, at least 4.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- vs  input  1  vertical sync from the generator.
- vld  input  1  active-pixel qualifier from the generator.
- rgb  input  3*PW  pixel data, sampled when vld=1.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream consumer ready.
- m_data  output  3*PW  stream pixel.
- m_sof  output  1  first pixel of a frame.
- m_eol  output  1  last pixel of a line.
- ovf_clr  input  1  clears the overflow flag.
- overflow  output  1  sticky flag: a pixel was dropped.
- line_pixels  output  H_BITS  pixel count of the last completed line.
- frame_lines  output  V_BITS  line count of the last completed frame.

Behaviour:
- Reset (rst_n=0 at a clk edge): FIFO empty; m_valid=0; overflow=0; line_pixels=0; frame_lines=0; hold register empty; vs_d=0; state WAIT_VS. m_data, m_sof and m_eol are don't-care while m_valid=0.
- Reset mid-frame discards all buffered pixels. No partial frame is emitted.
- vs rising edge (vs_rise): vs=1 and vs_d=0; vs_d is vs registered.
- State machine:
  - WAIT_VS: all input pixels ignored. On vs_rise -> ARMED.
  - ARMED: the first cycle with vld=1 captures that pixel with sof=1 -> FRAME.
  - FRAME: every vld=1 pixel is captured with sof=0. On vs_rise -> ARMED.
  - If vs_rise and vld=1 occur in the same cycle, the transition is taken and that pixel is treated as the first pixel of the new frame (sof=1).
- Hold stage (one-pixel lookahead to produce eol):
  - A captured pixel goes into the hold register.
  - On the next cycle, if hold is full: push hold to the FIFO with eol = ~vld.
  - Hold is then reloaded with the new pixel if vld=1, else it becomes empty.
  - A pixel followed by vld=0 is always eol, even if it is the only pixel of the line.
  - In WAIT_VS the hold register still drains, so a line in progress at the vs edge ends correctly.
- FIFO:
  - Entries are {sof, eol, data}; read is first-word-fall-through.
  - m_valid = (count != 0); m_data, m_sof and m_eol come from the head entry.
  - Pop when m_valid & m_ready.
  - Push is accepted only if count < DEPTH before the pop of that cycle. A push when full is dropped and overflow is set, even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Latency: pixel at input in cycle n is visible at m_data in cycle n+2 earliest (FIFO empty, m_ready=1). Sustained throughput is 1 pixel/cycle.
- overflow:
  - Set on a dropped push; cleared by ovf_clr.
  - If the set condition and ovf_clr occur in the same cycle, set wins.
  - Dropped pixels are not replayed. Downstream resynchronises on the next m_sof.
- Measurement (counts pushes attempted, independent of drops):
  - pix_cnt increments on each hold push.
  - On an eol push: line_pixels <= pix_cnt+1, pix_cnt <= 0, line_cnt increments.
  - On an sof push: frame_lines <= line_cnt (this skips the first frame after reset, where frame_lines stays 0), line_cnt <= 0.
  - All counters wrap silently at their width.

Test Plan:
- Frame of 4 lines x 8 pixels, rgb = incrementing 0x000000.., m_ready=1 -> 32 beats in order; m_sof on the first beat only; m_eol on beats 8/16/24/32; first beat 2 cycles after the first vld; after the 2nd frame's sof, line_pixels=8 and frame_lines=4.
- After reset, vld pixels before the first vs rise -> nothing emitted. m_valid stays 0 until 2 cycles after the first vld following vs_rise.
- m_ready=0 for a 20-pixel line with DEPTH=16 -> 16 entries held; overflow=1; pixels 17-20 lost. Releasing m_ready -> exactly 16 beats, last has eol=0. Pulsing ovf_clr -> overflow=0.
- Single-pixel lines (vld high for 1 cycle) and vs_rise coinciding with vld=1 -> every pixel has eol=1; the coincident pixel carries sof=1.
- Random m_ready (50%) over 3 frames of 6x10 -> no drops; data/sof/eol sequence matches the reference model; overflow stays 0.
- rst_n asserted mid-line with 5 entries buffered -> next cycle m_valid=0; overflow=0; line_pixels=0; no further output until a new vs_rise.

Source files
------------

// File: rtl/vtpg_stream_adapter.sv
// ----------------------------------------------------------------------------
// vtpg_stream_adapter: VTPG pixel timing (vs/vld/rgb) to valid/ready stream
// with sof/eol markers, elastic FWFT FIFO and line/frame size measurement.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vtpg_stream_adapter #(
  parameter int PW     = 8,
  parameter int H_BITS = 12,
  parameter int V_BITS = 12,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vs,
  input  logic              vld,
  input  logic [3*PW-1:0]   rgb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [3*PW-1:0]   m_data,
  output logic              m_sof,
  output logic              m_eol,
  input  logic              ovf_clr,
  output logic              overflow,
  output logic [H_BITS-1:0] line_pixels,
  output logic [V_BITS-1:0] frame_lines
);

  localparam int DW = 3 * PW;
  localparam int EW = DW + 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ARMED   = 2'd1,
    FRAME   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              vs_d_q;
  logic              hold_v_q, hold_sof_q;
  logic [DW-1:0]     hold_data_q;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q;
  logic [H_BITS-1:0] pix_cnt_q, line_pixels_q;
  logic [V_BITS-1:0] line_cnt_q, frame_lines_q;

  logic vs_rise, start_ok, cap, cap_sof;
  logic push, push_eol, full, push_ok, pop, drop;
  logic [EW-1:0] head;

  // A vs rise in the same cycle as vld makes that pixel the frame's first.
  always_comb begin
    vs_rise  = vs & ~vs_d_q;
    start_ok = vs_rise | (state_q == ARMED);
    cap      = vld & (start_ok | (state_q == FRAME));
    cap_sof  = vld & start_ok;
    state_d  = state_q;
    if (cap) begin
      state_d = FRAME;
    end else if (vs_rise) begin
      state_d = ARMED;
    end
  end

  always_comb begin
    push     = hold_v_q;
    push_eol = ~vld;
    full     = (count_q == CW'(DEPTH));
    push_ok  = push & ~full;
    drop     = push & full;
    pop      = (count_q != '0) & m_ready;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_VS;
      vs_d_q      <= 1'b0;
      hold_v_q    <= 1'b0;
      hold_sof_q  <= 1'b0;
      hold_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_d_q      <= vs;
      hold_v_q    <= cap;
      hold_sof_q  <= cap_sof;
      hold_data_q <= rgb;
      count_q     <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {hold_sof_q, push_eol, hold_data_q};
  end

  // Measurement follows attempted pushes, so dropped pixels still count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_pixels_q <= '0;
      frame_lines_q <= '0;
    end else if (push) begin
      if (push_eol) begin
        line_pixels_q <= pix_cnt_q + H_BITS'(1);
        pix_cnt_q     <= '0;
      end else begin
        pix_cnt_q <= pix_cnt_q + H_BITS'(1);
      end
      if (hold_sof_q) begin
        frame_lines_q <= line_cnt_q;
        line_cnt_q    <= push_eol ? V_BITS'(1) : '0;
      end else if (push_eol) begin
        line_cnt_q <= line_cnt_q + V_BITS'(1);
      end
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign m_valid     = (count_q != '0);
  assign m_data      = head[DW-1:0];
  assign m_eol       = head[DW];
  assign m_sof       = head[DW+1];
  assign overflow    = overflow_q;
  assign line_pixels = line_pixels_q;
  assign frame_lines = frame_lines_q;

endmodule

`default_nettype wire

// File: tb/tb_vtpg_stream_adapter.sv
// ----------------------------------------------------------------------------
// tb_vtpg_stream_adapter: scoreboard bench for vtpg_stream_adapter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vtpg_stream_adapter;

  localparam int PW     = 8;
  localparam int H_BITS = 12;
  localparam int V_BITS = 12;
  localparam int DEPTH  = 16;
  localparam int DW     = 3 * PW;

  logic              clk = 1'b0;
  logic              rst_n, vs, vld, m_ready, ovf_clr;
  logic [DW-1:0]     rgb;
  logic              m_valid, m_sof, m_eol, overflow;
  logic [DW-1:0]     m_data;
  logic [H_BITS-1:0] line_pixels;
  logic [V_BITS-1:0] frame_lines;

  int            checks   = 0;
  int            failures = 0;
  int            rdy_mode = 1;
  logic [DW+1:0] sb [$];
  logic [DW-1:0] pix_val;

  always #5 clk = ~clk;

  vtpg_stream_adapter #(
    .PW(PW), .H_BITS(H_BITS), .V_BITS(V_BITS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vs(vs), .vld(vld), .rgb(rgb),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .ovf_clr(ovf_clr), .overflow(overflow),
    .line_pixels(line_pixels), .frame_lines(frame_lines)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Ready driver: 0 = stalled, 1 = always ready, 2 = random 50%.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    logic [DW+1:0] exp_beat;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
        check_eq("beat_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() != 0) begin
          exp_beat = sb.pop_front();
          check_eq("beat", {6'd0, m_sof, m_eol, m_data}, {6'd0, exp_beat});
        end
      end
    end
  end

  task automatic px(input logic s, input logic sof, input logic eol, input logic exp_it);
    @(posedge clk); #1;
    vs = s; vld = 1'b1; rgb = pix_val;
    if (exp_it) sb.push_back({sof, eol, pix_val});
    pix_val = pix_val + 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      vs = 1'b0; vld = 1'b0;
    end
  endtask

  task automatic vsync();
    @(posedge clk); #1;
    vs = 1'b1; vld = 1'b0;
    idle(1);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      idle(1);
      n++;
    end
    check_eq("drain_left", sb.size(), 0);
  endtask

  task automatic frame(input int lines, input int ppl, input bit chk_lat, input bit drain_gap);
    vsync();
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        px(1'b0, (l == 0 && p == 0), (p == ppl - 1), 1'b1);
        if (chk_lat && l == 0 && p == 1) check_eq("lat_n1_valid", m_valid, 0);
        if (chk_lat && l == 0 && p == 2) check_eq("lat_n2_valid", m_valid, 1);
      end
      idle(1);
      if (drain_gap) drain(200);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int valid_seen;
    rst_n = 1'b0; vs = 1'b0; vld = 1'b0; rgb = '0; ovf_clr = 1'b0;
    pix_val = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst_valid", m_valid, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_line_pixels", line_pixels, 0);
    check_eq("rst_frame_lines", frame_lines, 0);

    // Pixels before the first vs rise are ignored.
    for (int i = 0; i < 5; i++) px(1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    check_eq("pre_vs_valid", m_valid, 0);

    // Two 4x8 frames, always ready.
    pix_val = '0;
    frame(4, 8, 1'b1, 1'b0);
    drain(100);
    check_eq("f1_line_pixels", line_pixels, 8);
    check_eq("f1_frame_lines", frame_lines, 0);
    frame(4, 8, 1'b0, 1'b0);
    drain(100);
    check_eq("f2_line_pixels", line_pixels, 8);
    check_eq("f2_frame_lines", frame_lines, 4);

    // Overflow: 20-pixel line into a stalled 16-entry FIFO.
    rdy_mode = 0;
    idle(2);
    vsync();
    for (int p = 0; p < 20; p++) px(1'b0, (p == 0), 1'b0, (p < 16));
    idle(4);
    check_eq("ovf_set", overflow, 1);
    check_eq("ovf_valid", m_valid, 1);
    check_eq("ovf_line_pixels", line_pixels, 20);
    rdy_mode = 1;
    drain(100);
    idle(5);
    check_eq("ovf_sticky", overflow, 1);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    check_eq("ovf_cleared", overflow, 0);

    // Single-pixel lines and a vs rise coincident with vld.
    vsync();
    for (int i = 0; i < 3; i++) begin
      px(1'b0, (i == 0), 1'b1, 1'b1);
      idle(1);
    end
    px(1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    px(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    drain(100);
    check_eq("single_line_pixels", line_pixels, 1);

    // Three 6x10 frames with random back-pressure.
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) frame(6, 10, 1'b0, 1'b1);
    rdy_mode = 1;
    drain(200);
    check_eq("rand_overflow", overflow, 0);
    check_eq("rand_frame_lines", frame_lines, 6);
    check_eq("rand_line_pixels", line_pixels, 10);

    // Reset mid-line with 5 entries buffered.
    rdy_mode = 0;
    idle(2);
    vsync();
    for (int p = 0; p < 6; p++) px(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq("pre_rst_valid", m_valid, 1);
    rst_n = 1'b0; vld = 1'b1; rgb = pix_val;
    @(posedge clk); #1;
    rst_n = 1'b1; vld = 1'b0;
    check_eq("mid_rst_valid", m_valid, 0);
    check_eq("mid_rst_overflow", overflow, 0);
    check_eq("mid_rst_line_pixels", line_pixels, 0);
    check_eq("mid_rst_frame_lines", frame_lines, 0);
    rdy_mode = 1;
    valid_seen = 0;
    for (int p = 0; p < 10; p++) begin
      px(1'b0, 1'b0, 1'b0, 1'b0);
      if (m_valid) valid_seen++;
    end
    idle(3);
    if (m_valid) valid_seen++;
    check_eq("post_rst_no_output", valid_seen, 0);
    frame(1, 4, 1'b0, 1'b0);
    drain(100);
    check_eq("recover_line_pixels", line_pixels, 4);

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
